// File: rtl/codificador_pt2262.sv
// codificador_pt2262: PT2262-style tri-state encoder, 8 address trits + 4 data bits + sync per frame
module codificador_pt2262 #(
  parameter int DIVIDER = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [3:0]  D,
  input  logic        te,
  output logic        cod_o,
  output logic        busy,
  output logic        frame_done
);
  localparam int DW = DIVIDER > 1 ? $clog2(DIVIDER) : 1;
  typedef enum logic [1:0] {IDLE, SEND_WORD, SEND_SYNC} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic          tick;
  logic [6:0]    phase, phase_n;
  logic [3:0]    word_idx, word_n;
  logic [15:0]   a_sh, a_n;
  logic [3:0]    d_sh, d_n;
  logic          busy_n, cod_n, done_n, start, half_bit;
  logic [1:0]    trit;
  assign tick = div == DW'(DIVIDER - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      word_idx   <= '0;
      a_sh       <= '0;
      d_sh       <= '0;
      cod_o      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      word_idx   <= word_n;
      a_sh       <= a_n;
      d_sh       <= d_n;
      cod_o      <= cod_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  // cod_o is the level of the position being entered, so it is decided from the next-state values
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    word_n   = word_idx;
    a_n      = a_sh;
    d_n      = d_sh;
    busy_n   = busy;
    cod_n    = cod_o;
    done_n   = 1'b0;
    start    = 1'b0;
    trit     = '0;
    half_bit = 1'b0;
    if (tick) begin
      case (state)
        IDLE: start = te;
        SEND_WORD: begin
          phase_n = phase + 7'd1;
          if (phase[4:0] == 5'd31) begin
            phase_n = '0;
            if (word_idx == 4'd11) state_n = SEND_SYNC;
            else word_n = word_idx + 4'd1;
          end
        end
        default: begin
          phase_n = phase + 7'd1;
          if (phase == 7'd127) begin
            done_n = 1'b1;
            start  = te;
            if (!te) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              phase_n = '0;
              word_n  = '0;
            end
          end
        end
      endcase
      if (start) begin
        state_n = SEND_WORD;
        a_n     = A;
        d_n     = D;
        phase_n = '0;
        word_n  = '0;
        busy_n  = 1'b1;
      end
      // data bits reuse the trit path as 00/11; F (01/10) gives halves (0,1)
      trit     = word_n[3] ? {2{d_n[word_n[1:0]]}} : a_n[{word_n[2:0], 1'b0} +: 2];
      half_bit = phase_n[4] ? |trit : &trit;
      cod_n    = state_n == SEND_SYNC ? phase_n < 7'd4 :
                 state_n == SEND_WORD ? phase_n[3:0] < (half_bit ? 4'd12 : 4'd4) : 1'b0;
    end
  end
endmodule

// File: tb/tb_codificador_pt2262.sv
// tb_codificador_pt2262: checks every tick of each frame against a frame-level waveform model
module tb_codificador_pt2262;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b0, te = 1'b0;
  logic [15:0] A = 16'hFFFF;
  logic [3:0]  D = 4'hF;
  logic cod_o, busy, frame_done;
  int total = 0, bad = 0;
  logic [15:0] ra, ra2, ra3;
  logic [3:0]  rd, rd2, rd3;
  codificador_pt2262 #(.DIVIDER(DIV)) dut (
    .clk(clk), .reset(reset), .A(A), .D(D), .te(te),
    .cod_o(cod_o), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [511:0] frame_bits(input logic [15:0] a, input logic [3:0] d);
    logic [511:0] r;
    logic [1:0] ab;
    int t;
    logic h0, h1;
    r = '0;
    for (int w = 0; w < 12; w++) begin
      if (w < 8) begin
        ab = a[2*w +: 2];
        t = ab == 2'b00 ? 0 : ab == 2'b11 ? 1 : 2;
      end else t = int'(d[w-8]);
      h0 = t == 1;
      h1 = t != 0;
      for (int p = 0; p < 16; p++) begin
        r[w*32+p]    = p < (h0 ? 12 : 4);
        r[w*32+16+p] = p < (h1 ? 12 : 4);
      end
    end
    for (int p = 0; p < 128; p++) r[384+p] = p < 4;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick_wait();
    repeat (DIV) @(posedge clk);
    #1;
  endtask
  // entered at the sample of phase 0 of word 0; leaves at the sample right after the frame's last tick
  task automatic expect_frame(input logic [15:0] a, input logic [3:0] d, input logic first_done,
                              input int n, input logic [15:0] na, input logic [3:0] nd, input logic nte);
    logic [511:0] e;
    e = frame_bits(a, d);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cod[%0d]", i), 32'(cod_o), 32'(e[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      chk($sformatf("done[%0d]", i), 32'(frame_done), 32'(i == 0 && first_done));
      if (i == 100) begin
        A = na;
        D = nd;
        te = nte;
      end
      if (i < n - 1 || n == 512) tick_wait();
    end
  endtask
  initial begin
    te = 1'b1;
    #2;
    chk("rst_cod", 32'(cod_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (DIV - 1) @(posedge clk);
    #1 chk("pre_tick_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("first_tick_busy", 32'(busy), 32'd1);
    expect_frame(16'hFFFF, 4'hF, 1'b0, 512, 16'hFFFF, 4'hF, 1'b1);
    expect_frame(16'hFFFF, 4'hF, 1'b1, 512, 16'h0000, 4'h0, 1'b1);
    expect_frame(16'h0000, 4'h0, 1'b1, 512, 16'hFFFF, 4'h0, 1'b1);
    expect_frame(16'hFFFF, 4'h0, 1'b1, 512, 16'hAAAA, 4'b0101, 1'b0);
    chk("end_done", 32'(frame_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_cod", 32'(cod_o), 32'd0);
    tick_wait();
    chk("idle_done", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    #4 te = 1'b1;
    #10 te = 1'b0;
    repeat (DIV - 1) @(posedge clk);
    #1 chk("short_te_busy", 32'(busy), 32'd0);
    chk("short_te_cod", 32'(cod_o), 32'd0);
    te = 1'b1;
    tick_wait();
    ra = 16'($urandom);
    rd = 4'($urandom);
    ra2 = 16'($urandom);
    rd2 = 4'($urandom);
    expect_frame(16'hAAAA, 4'b0101, 1'b0, 512, ra, rd, 1'b1);
    expect_frame(ra, rd, 1'b1, 512, ra2, rd2, 1'b1);
    expect_frame(ra2, rd2, 1'b1, 170, ra2, rd2, 1'b1);
    #3 reset = 1'b0;
    #1 chk("abort_cod", 32'(cod_o), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ra3 = 16'($urandom);
    rd3 = 4'($urandom);
    A = ra3;
    D = rd3;
    #2 reset = 1'b1;
    repeat (DIV - 1) @(posedge clk);
    #1 chk("rel_pre_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("rel_busy", 32'(busy), 32'd1);
    expect_frame(ra3, rd3, 1'b0, 512, ra3, rd3, 1'b0);
    chk("final_done", 32'(frame_done), 32'd1);
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_cod", 32'(cod_o), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
